// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N oversample/bit tick generator for a UART.
// A period counter produces 'tick' every act_int (+carry) enabled cycles, and a
// tick counter produces 'bit_tick' on every OVERSAMPLE-th tick. New divisors are
// staged in shadow registers and take effect at the next tick or on restart.
// Optional feature: define BAUD_GEN_FRAC_EN to build the fractional accumulator
// (acc/carry, act_frac/shd_frac). Without it the divisor is integer-only and
// div_frac is ignored.
module baud_gen_frac #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 19200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              tick,
  output logic              bit_tick,
  output logic              load_pend
);

  // The counter must reach act_int (max) when a carry stretches the period.
  localparam int CNT_W = DIV_W + 1;
  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);

`ifdef BAUD_GEN_FRAC_EN
  localparam longint RST_DIV = (longint'(CLK_FREQ) << FRAC_W) /
                               (longint'(BAUD_RATE) * longint'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_DIV >> FRAC_W);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV);
`else
  localparam longint RST_DIV = longint'(CLK_FREQ) /
                               (longint'(BAUD_RATE) * longint'(OVERSAMPLE));
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_DIV);
`endif

  logic [DIV_W-1:0] act_int_q, act_int_d;
  logic [DIV_W-1:0] shd_int_q, shd_int_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic             load_pend_q, load_pend_d;
  logic             carry_use;
  logic [CNT_W-1:0] period;
  logic             tick_c;
  logic             apply_div;

  // Current period length and the terminal-count tick; divisors of 0/1 tick every cycle.
  always_comb begin
    if (act_int_q <= DIV_W'(1)) period = CNT_W'(1);
    else                        period = CNT_W'(act_int_q) + CNT_W'(carry_use);
    tick_c    = !reset && !restart && en && (cnt_q == period - CNT_W'(1));
    apply_div = restart || tick_c;
  end

  assign tick      = tick_c;
  assign bit_tick  = tick_c && (sub_q == SUB_LAST);
  assign load_pend = load_pend_q;

  // Next-state for counters and integer divisor; a coincident load goes straight to active.
  always_comb begin
    cnt_d       = cnt_q;
    sub_d       = sub_q;
    shd_int_d   = div_load ? div_int : shd_int_q;
    act_int_d   = apply_div ? shd_int_d : act_int_q;
    load_pend_d = apply_div ? 1'b0 : (load_pend_q || div_load);
    if (restart) begin
      cnt_d = '0;
      sub_d = '0;
    end else if (tick_c) begin
      cnt_d = '0;
      sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + SUB_W'(1);
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset to the build-time baud divisor.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      sub_q       <= '0;
      load_pend_q <= 1'b0;
      act_int_q   <= RST_INT;
      shd_int_q   <= RST_INT;
    end else begin
      cnt_q       <= cnt_d;
      sub_q       <= sub_d;
      load_pend_q <= load_pend_d;
      act_int_q   <= act_int_d;
      shd_int_q   <= shd_int_d;
    end
  end

`ifdef BAUD_GEN_FRAC_EN
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;

  assign carry_use = carry_q;

  // Phase accumulator: its overflow on a tick stretches the following period by one cycle.
  always_comb begin
    shd_frac_d = div_load ? div_frac : shd_frac_q;
    act_frac_d = apply_div ? shd_frac_d : act_frac_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    if (restart) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (tick_c) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
    end
  end

  // Fractional registers share the synchronous reset of the integer path.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_frac_q <= RST_FRAC;
      shd_frac_q <= RST_FRAC;
      acc_q      <= '0;
      carry_q    <= 1'b0;
    end else begin
      act_frac_q <= act_frac_d;
      shd_frac_q <= shd_frac_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
    end
  end
`else
  logic unused_div_frac;

  assign carry_use       = 1'b0;
  assign unused_div_frac = ^div_frac;
`endif

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 19200, reset-time baud rate.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, ticks per bit, legal range 2..64.
REQ-004 SHALL have parameter DIV_W, default 16, integer divisor width.
REQ-005 SHALL have parameter FRAC_W, default 4, fractional divisor width.
REQ-006 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: en  in  1  count enable; restart  in  1  phase resynchronise pulse.
REQ-008 SHALL have ports: div_int  in  DIV_W  integer divisor; div_frac  in  FRAC_W  fractional divisor; div_load  in  1  divisor load strobe.
REQ-009 SHALL have ports: tick  out  1  oversample tick; bit_tick  out  1  bit-period tick; load_pend  out  1  divisor load pending.

Function
REQ-010 SHALL hold active divisor registers act_int/act_frac and shadow registers shd_int/shd_frac.
REQ-011 SHALL count a period counter cnt from 0; tick=1 when en=1 and cnt==period-1, where period = act_int + carry; otherwise tick=0; cnt wraps to 0 on tick.
REQ-012 SHALL treat act_int of 0 or 1 as 1: tick every enabled cycle, carry ignored.
REQ-013 SHALL, on each tick, update acc <= (acc + act_frac) mod 2^FRAC_W; carry = overflow of that add, registered, applied to the next period only.
REQ-014 SHALL count ticks in sub (0..OVERSAMPLE-1, wraps); bit_tick=1 in the same cycle as a tick when sub==OVERSAMPLE-1.
REQ-015 SHALL freeze cnt, sub, acc and carry while en=0; tick and bit_tick are 0.
REQ-016 SHALL, on div_load=1, capture div_int/div_frac into the shadow registers and set load_pend=1; a later div_load overwrites the shadow registers.
REQ-017 SHALL copy the shadow into the active registers and clear load_pend in the cycle that a tick occurs; the new divisor governs the next period, and acc is not cleared.
REQ-018 SHALL, on restart=1, clear cnt, sub, acc and carry next cycle, suppress tick that cycle, and apply any pending load immediately.
REQ-019 SHALL, when div_load and a tick coincide, make the newly captured values active at that tick, with load_pend=0.
REQ-020 SHALL give restart priority over en; reset has priority over all.

Reset
REQ-021 SHALL, on reset, set cnt=0, sub=0, acc=0, carry=0 and load_pend=0; tick and bit_tick are 0 during reset.
REQ-022 SHALL, on reset, set act and shd to D = floor(CLK_FREQ*2^FRAC_W/(BAUD_RATE*OVERSAMPLE)): int = D>>FRAC_W, frac = D mod 2^FRAC_W. Defaults give int 325 and frac 8.

Configuration
REQ-023 SHALL, with macro BAUD_GEN_FRAC_EN defined, implement acc/carry per REQ-013.
REQ-024 SHALL, without BAUD_GEN_FRAC_EN, omit acc, carry and frac registers: div_frac ignored, period = act_int, reset int = floor(CLK_FREQ/(BAUD_RATE*OVERSAMPLE)).

Verification
REQ-025 SHALL cover default parameters with en=1 after reset: first tick at cycle 325 after reset release, periods then follow the 325/326 pattern of REQ-013, and bit_tick fires on every 16th tick.
REQ-026 SHALL cover load div_int=4, div_frac=8 then restart: tick periods 4,4,5,4,5,... cycles; with macro undefined, 4,4,4,...
REQ-027 SHALL cover div_load of int 10 mid-period with int 4 active: load_pend=1 until the next tick, that period stays 4, following periods are 10.
REQ-028 SHALL cover en=0 for 7 cycles mid-period: no ticks, and the period resumes with the remaining count unchanged.
REQ-029 SHALL cover restart asserted in the same cycle as a tick: no tick output, and the next tick occurs act_int cycles later with sub=0.
REQ-030 SHALL cover div_int=0 and div_int=1: tick every enabled cycle, and bit_tick every OVERSAMPLE cycles.
